// File: rtl/ac97_pkg.sv
// Shared AC-link frame geometry, codec register map and command-entry type.
package ac97_pkg;

   localparam int FRAME_BITS  = 256;
   localparam int TAG_BITS    = 16;
   localparam int SLOT_BITS   = 20;

   localparam int SLOT1_START = 16;
   localparam int SLOT2_START = 36;
   localparam int SLOT3_START = 56;
   localparam int SLOT4_START = 76;
   localparam int SLOT5_START = 96;

   localparam logic [6:0] REG_MASTER_VOL  = 7'h02;
   localparam logic [6:0] REG_HP_VOL      = 7'h04;
   localparam logic [6:0] REG_PCM_OUT_VOL = 7'h18;
   localparam logic [6:0] REG_REC_SEL     = 7'h1A;

   // Frame valid plus slots 1..4 valid; tag bit 0 is the MSB on the wire.
   localparam logic [TAG_BITS-1:0] TAG_WORD = 16'hF800;

   typedef struct packed {
      logic [6:0]  addr;
      logic [15:0] data;
   } cmd_entry_t;

   // Stereo attenuation word: {2'b00, A, 2'b00, A} with A = {vol, 2'b00}.
   function automatic logic [15:0] vol_word(input logic [3:0] vol);
      return {2'b00, vol, 2'b00, 2'b00, vol, 2'b00};
   endfunction

endpackage

// File: rtl/ac97_link_controller_if.sv
// Sample FIFO read port: master is the consumer (link controller), slave the FIFO.
interface ac97_link_controller_if #(
   parameter int W = 20
) ();
   logic [W-1:0] sample_fifo_tone_data;
   logic         sample_fifo_empty;
   logic         sample_fifo_rd_en;

   modport master (
      input  sample_fifo_tone_data,
      input  sample_fifo_empty,
      output sample_fifo_rd_en
   );

   modport slave (
      output sample_fifo_tone_data,
      output sample_fifo_empty,
      input  sample_fifo_rd_en
   );
endinterface

// File: rtl/ac97_cmd_sequencer.sv
// Round-robin codec register-write list; volume is latched once per frame.
module ac97_cmd_sequencer
   import ac97_pkg::*;
#(
   parameter logic [15:0] PCM_OUT_GAIN = 16'h0808
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       advance_i,
   input  logic       vol_load_i,
   input  logic [3:0] volume_i,
   output cmd_entry_t cmd_o
);

   logic [1:0] idx_q, idx_d;
   logic [3:0] vol_q, vol_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q <= 2'd0;
         vol_q <= 4'd0;
      end else begin
         idx_q <= idx_d;
         vol_q <= vol_d;
      end
   end

   always_comb begin
      idx_d = idx_q;
      vol_d = vol_q;
      if (advance_i)  idx_d = idx_q + 2'd1;
      if (vol_load_i) vol_d = volume_i;
   end

   always_comb begin
      cmd_o = '0;
      case (idx_q)
         2'd0:    cmd_o = '{addr: REG_MASTER_VOL,  data: vol_word(vol_q)};
         2'd1:    cmd_o = '{addr: REG_HP_VOL,      data: vol_word(vol_q)};
         2'd2:    cmd_o = '{addr: REG_PCM_OUT_VOL, data: PCM_OUT_GAIN};
         default: cmd_o = '{addr: REG_REC_SEL,     data: 16'h0000};
      endcase
   end

endmodule

// File: rtl/ac97_link_controller.sv
// AC-link frame serializer: tag, command slots 1/2, PCM slots 3/4 from a sample FIFO.
// Build option AC97_MUTE_ON_EMPTY_EN: frames without a FIFO pop transmit silence.
module ac97_link_controller
   import ac97_pkg::*;
#(
   parameter int          SAMPLE_WIDTH = 20,
   parameter logic [15:0] PCM_OUT_GAIN = 16'h0808
) (
   input  logic                          bit_clk,
   input  logic                          system_reset,
   input  logic                          sdata_in,
   output logic                          sdata_out,
   output logic                          sync,
   output logic                          reset_b,
   ac97_link_controller_if.master        fifo,
   input  logic [3:0]                    volume_control
);

   logic [7:0]              cnt_q, cnt_d;
   logic                    sync_q, sync_d;
   logic                    sdata_q, sdata_d;
   logic                    popped_q, popped_d;
   logic [SAMPLE_WIDTH-1:0] sample_q, sample_d;
   logic                    rd_en;
   cmd_entry_t              cmd_w;
   logic [SLOT_BITS-1:0]    slot1_w, slot2_w;
   logic [FRAME_BITS-1:0]   frame_w;
   wire                     unused_sdata_in = sdata_in;

   assign reset_b   = ~system_reset;
   assign sync      = sync_q;
   assign sdata_out = sdata_q;

   assign rd_en = (cnt_q == 8'd0) && !fifo.sample_fifo_empty && !system_reset;
   assign fifo.sample_fifo_rd_en = rd_en;

   ac97_cmd_sequencer #(
      .PCM_OUT_GAIN (PCM_OUT_GAIN)
   ) u_cmd_seq (
      .clk        (bit_clk),
      .rst        (system_reset),
      .advance_i  (cnt_q == 8'(SLOT3_START - 1)),
      .vol_load_i (cnt_q == 8'd0),
      .volume_i   (volume_control),
      .cmd_o      (cmd_w)
   );

   assign slot1_w = {1'b0, cmd_w.addr, 12'h000};
   assign slot2_w = {cmd_w.data, 4'h0};
   assign frame_w = {TAG_WORD, slot1_w, slot2_w, sample_q, sample_q,
                     {(FRAME_BITS - SLOT5_START){1'b0}}};

   always_ff @(posedge bit_clk or posedge system_reset) begin
      if (system_reset) begin
         cnt_q    <= 8'hFF;
         sync_q   <= 1'b0;
         sdata_q  <= 1'b0;
         popped_q <= 1'b0;
         sample_q <= '0;
      end else begin
         cnt_q    <= cnt_d;
         sync_q   <= sync_d;
         sdata_q  <= sdata_d;
         popped_q <= popped_d;
         sample_q <= sample_d;
      end
   end

   // Outputs are registered for the bit being entered, so decode cnt_d.
   always_comb begin
      cnt_d    = cnt_q + 8'd1;
      sync_d   = (cnt_d < 8'(TAG_BITS));
      sdata_d  = frame_w[~cnt_d];
      popped_d = popped_q;
      sample_d = sample_q;
      if (cnt_q == 8'd0) popped_d = rd_en;
      // Non-FWFT FIFO: read data is valid the cycle after the pop.
      if (cnt_q == 8'd1) begin
         if (popped_q) begin
            sample_d = fifo.sample_fifo_tone_data;
         end
`ifdef AC97_MUTE_ON_EMPTY_EN
         else begin
            sample_d = '0;
         end
`endif
      end
   end

endmodule

// File: tb/tb_ac97_link_controller.sv
// Frame-decoding scoreboard bench for ac97_link_controller with a behavioural FIFO.
module tb_ac97_link_controller;

   logic       bit_clk = 1'b0;
   logic       system_reset;
   logic       sdata_in;
   logic       sdata_out;
   logic       sync;
   logic       reset_b;
   logic [3:0] volume_control;

   ac97_link_controller_if #(.W(20)) fifo_if ();

   ac97_link_controller dut (
      .bit_clk        (bit_clk),
      .system_reset   (system_reset),
      .sdata_in       (sdata_in),
      .sdata_out      (sdata_out),
      .sync           (sync),
      .reset_b        (reset_b),
      .fifo           (fifo_if.master),
      .volume_control (volume_control)
   );

   always #5 bit_clk = ~bit_clk;

   int tests_run    = 0;
   int tests_failed = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Behavioural standard FIFO: pop request seen low-phase, data updates on the next rise.
   logic [19:0] fifo_q[$];
   logic [19:0] exp_q[$];
   bit          pop_req = 1'b0;
   int          total_pops = 0;

   always @(negedge bit_clk) begin
      pop_req = fifo_if.sample_fifo_rd_en && (fifo_q.size() != 0);
      fifo_if.sample_fifo_empty = (fifo_q.size() == 0);
   end

   always @(posedge bit_clk) begin
      if (pop_req) begin
         fifo_if.sample_fifo_tone_data <= fifo_q.pop_front();
         total_pops++;
      end
   end

   // Codec-side decoder and reference model.
   logic [0:255] fb;
   int           bitpos     = 0;
   int           rd_cnt     = 0;
   int           sync_err   = 0;
   int           frames_done = 0;
   int           cmd_idx    = 0;
   bit           in_frame   = 1'b0;
   bit           sync_prev  = 1'b0;
   logic [3:0]   cur_vol;
   logic [19:0]  last_s     = '0;

   task automatic decode_frame();
      logic [19:0] exp_s, s1, s2, s3, s4;
      logic [6:0]  ea;
      logic [15:0] ed;
      int          exp_rd;
      if (exp_q.size() > 0) begin
         exp_s  = exp_q.pop_front();
         exp_rd = 1;
         last_s = exp_s;
      end else begin
         exp_rd = 0;
`ifdef AC97_MUTE_ON_EMPTY_EN
         exp_s = 20'h0;
`else
         exp_s = last_s;
`endif
      end
      case (cmd_idx)
         0:       begin ea = 7'h02; ed = {2'b00, cur_vol, 2'b00, 2'b00, cur_vol, 2'b00}; end
         1:       begin ea = 7'h04; ed = {2'b00, cur_vol, 2'b00, 2'b00, cur_vol, 2'b00}; end
         2:       begin ea = 7'h18; ed = 16'h0808; end
         default: begin ea = 7'h1A; ed = 16'h0000; end
      endcase
      s1 = fb[16 +: 20];
      s2 = fb[36 +: 20];
      s3 = fb[56 +: 20];
      s4 = fb[76 +: 20];
      $display("[TB] frame %0d cmd=%0d slot1=%h slot2=%h slot3=%h slot4=%h rd=%0d",
               frames_done, cmd_idx, s1, s2, s3, s4, rd_cnt);
      check_eq("tag", 32'(fb[0 +: 16]), 32'h0000F800);
      check_eq("slot1", 32'(s1), 32'({1'b0, ea, 12'h000}));
      check_eq("slot2", 32'(s2), 32'({ed, 4'h0}));
      check_eq("slot3", 32'(s3), 32'(exp_s));
      check_eq("slot4", 32'(s4), 32'(exp_s));
      check_eq("slots5_12", 32'(|fb[96:255]), 32'd0);
      check_eq("sync_shape", sync_err, 0);
      check_eq("rd_en_per_frame", rd_cnt, exp_rd);
      if (cmd_idx == 0 && cur_vol == 4'h3) begin
         check_eq("vol3_slot1", 32'(s1), 32'h00002000);
         check_eq("vol3_slot2", 32'(s2), 32'h000C0C0);
      end
      cmd_idx = (cmd_idx + 1) % 4;
      frames_done++;
   endtask

   always @(negedge bit_clk) begin
      if (system_reset) begin
         in_frame  = 1'b0;
         sync_prev = 1'b0;
         cmd_idx   = 0;
         last_s    = '0;
      end else begin
         if (sync && !sync_prev) begin
            if (in_frame) begin
               check_eq("sync_period", bitpos, 256);
               decode_frame();
            end
            in_frame = 1'b1;
            bitpos   = 0;
            rd_cnt   = 0;
            sync_err = 0;
            cur_vol  = volume_control;
         end
         if (in_frame) begin
            if (bitpos < 256) fb[bitpos] = sdata_out;
            if (sync !== (bitpos < 16)) sync_err++;
            if (fifo_if.sample_fifo_rd_en) rd_cnt++;
            bitpos++;
         end
         sync_prev = sync;
      end
   end

   task automatic wait_frames(input int n);
      int start = frames_done;
      int cyc   = 0;
      while (frames_done < start + n && cyc < n * 256 + 600) begin
         @(negedge bit_clk);
         cyc++;
      end
      check_eq("frames_seen", 32'(frames_done >= start + n), 32'd1);
   endtask

   task automatic wait_bit(input int target);
      int  cyc   = 0;
      bit  found = 1'b0;
      while (!found && cyc < 600) begin
         @(negedge bit_clk);
         #2;
         cyc++;
         if (in_frame && bitpos == target + 1) found = 1'b1;
      end
      check_eq("bit_reached", 32'(found), 32'd1);
   endtask

   int reset_bits[2] = '{100, 8};

   initial begin
      system_reset   = 1'b1;
      sdata_in       = 1'b0;
      volume_control = 4'h3;
      fifo_if.sample_fifo_tone_data = '0;
      for (int v = -50; v <= 50; v++) begin
         fifo_q.push_back(20'(v));
         exp_q.push_back(20'(v));
      end
      fifo_if.sample_fifo_empty = 1'b0;

      repeat (10) @(negedge bit_clk);
      #1;
      check_eq("reset_b_in_reset", 32'(reset_b), 32'd0);
      check_eq("sync_in_reset", 32'(sync), 32'd0);
      check_eq("sdata_in_reset", 32'(sdata_out), 32'd0);
      check_eq("rd_en_in_reset", 32'(fifo_if.sample_fifo_rd_en), 32'd0);
      system_reset = 1'b0;
      #1;
      check_eq("reset_b_after", 32'(reset_b), 32'd1);

      // 101 samples drain, then 10 frames with an empty FIFO.
      wait_frames(111);
      check_eq("total_pops", total_pops, 101);

      wait_bit(128);
      volume_control = 4'hA;
      wait_frames(5);

      foreach (reset_bits[i]) begin
         wait_bit(reset_bits[i]);
         system_reset = 1'b1;
         #1;
         check_eq("midreset_sync", 32'(sync), 32'd0);
         check_eq("midreset_sdata", 32'(sdata_out), 32'd0);
         check_eq("midreset_reset_b", 32'(reset_b), 32'd0);
         repeat (4) @(negedge bit_clk);
         #2;
         system_reset = 1'b0;
         #1;
         check_eq("midreset_release", 32'(reset_b), 32'd1);
         wait_frames(3);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
